rv_data_mem: RTL and testbench



---
 rtl/rv_mem_pkg.sv | 20 ++
 rtl/rv_dmem_addr_dec.sv | 23 ++
 rtl/rv_data_mem.sv | 78 +++++++
 tb/tb_rv_data_mem.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// rtl/rv_mem_pkg.sv - shared types and address helpers for the RISC-V data memory
// Contents: XLEN, WORD_BYTES, word_t, idx_of(), in_range()
package rv_mem_pkg;

   localparam int XLEN       = 32;
   localparam int WORD_BYTES = 4;

   typedef logic [XLEN-1:0] word_t;

   // Word number of a byte address; callers truncate to their own index width.
   function automatic word_t idx_of(input word_t addr);
      return addr >> $clog2(WORD_BYTES);
   endfunction

   // For a power-of-two depth this is equivalent to the upper address bits being zero.
   function automatic logic in_range(input word_t addr, input int depth);
      return idx_of(addr) < word_t'(depth);
   endfunction

endpackage

// File: rtl/rv_dmem_addr_dec.sv
// rtl/rv_dmem_addr_dec.sv - byte address decoder for the data memory
// Ports:
//   addr       in   byte address from the core
//   index      out  word index (addr[1:0] dropped, so misaligned addresses align down)
//   in_rng     out  address falls inside the DEPTH-word array
//   misaligned out  addr[1:0] != 0
module rv_dmem_addr_dec
   import rv_mem_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic [XLEN-1:0] addr,
   output logic [AW-1:0]   index,
   output logic            in_rng,
   output logic            misaligned
);

   assign index      = AW'(idx_of(addr));
   assign in_rng     = in_range(addr, DEPTH);
   assign misaligned = (addr[1:0] != 2'b00);

endmodule

// File: rtl/rv_data_mem.sv
// rtl/rv_data_mem.sv - word-organised data memory: combinational read, synchronous write
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset; clears every word
//   ce      in   access enable
//   we      in   write enable, qualified by ce
//   addr    in   byte address
//   data_i  in   store data
//   data_o  out  load data (0 unless an in-range read is in progress)
//   verify  out  contents of word VERIFY_IDX
//   err_o   out  sticky out-of-range / misaligned access flag (only with DMEM_ERR_EN)
// Optional feature macro: DMEM_ERR_EN
module rv_data_mem
   import rv_mem_pkg::*;
#(
   parameter int DEPTH      = 1024,
   parameter int VERIFY_IDX = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ce,
   input  logic            we,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] data_i,
   output logic [XLEN-1:0] data_o,
`ifdef DMEM_ERR_EN
   output logic            err_o,
`endif
   output logic [XLEN-1:0] verify
);

   localparam int            AW   = $clog2(DEPTH);
   localparam logic [AW-1:0] VIDX = AW'(VERIFY_IDX);

   word_t         mem [DEPTH];
   logic [AW-1:0] index;
   logic          in_rng;
   logic          misaligned;

   rv_dmem_addr_dec #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_dec (
      .addr       (addr),
      .index      (index),
      .in_rng     (in_rng),
      .misaligned (misaligned)
   );

   // Reset clears the whole array so loads and verify read 0 while rst is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (ce && we && in_rng) begin
         mem[index] <= data_i;
      end
   end

   assign data_o = (ce && !we && in_rng) ? mem[index] : '0;
   assign verify = mem[VIDX];

`ifdef DMEM_ERR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_o <= 1'b0;
      end else if (ce && (!in_rng || misaligned)) begin
         err_o <= 1'b1;
      end
   end
`else
   // Alignment only matters to the error flag.
   logic unused_misaligned;
   assign unused_misaligned = misaligned;
`endif

endmodule

// File: tb/tb_rv_data_mem.sv
// tb/tb_rv_data_mem.sv - randomized self-checking bench for rv_data_mem
module tb_rv_data_mem;

   localparam int DEPTH = 1024;
   localparam int VIDX  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic        we;
   logic [31:0] addr;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic [31:0] verify;
`ifdef DMEM_ERR_EN
   logic        err_o;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] model [DEPTH];
   logic        err_m;

   always #5 clk = ~clk;

   rv_data_mem #(
      .DEPTH      (DEPTH),
      .VERIFY_IDX (VIDX)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .ce     (ce),
      .we     (we),
      .addr   (addr),
      .data_i (data_i),
      .data_o (data_o),
`ifdef DMEM_ERR_EN
      .err_o  (err_o),
`endif
      .verify (verify)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   function automatic bit addr_ok(input logic [31:0] a);
      return (a / 4) < DEPTH;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      err_m = 1'b0;
   endtask

   // One access cycle: apply inputs, check combinational outputs before the edge,
   // then apply the memory rules to the model at the edge.
   task automatic step(input string tag, input logic c, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
      logic [31:0] exp_rd;
      ce = c; we = w; addr = a; data_i = d;
      @(negedge clk);
      exp_rd = (c && !w && addr_ok(a)) ? model[a / 4] : 32'h0;
      check({tag, "_data_o"}, data_o, exp_rd);
      check({tag, "_verify"}, verify, model[VIDX]);
`ifdef DMEM_ERR_EN
      check({tag, "_err"}, {31'h0, err_o}, {31'h0, err_m});
`endif
      @(posedge clk);
      if (c && w && addr_ok(a)) model[a / 4] = d;
      if (c && (!addr_ok(a) || a[1:0] != 2'b00)) err_m = 1'b1;
      #1;
   endtask

   initial begin
      rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; data_i = '0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check("por_data_o", data_o, 32'h0);
      check("por_verify", verify, 32'h0);
      rst = 1'b0;

      // Preload word 2, then hold reset for three cycles.
      step("preload", 1'b1, 1'b1, 32'h8, 32'hDEADBEEF);
      check("preload_verify", verify, 32'hDEADBEEF);
      ce = 1'b1; we = 1'b0; addr = 32'h8;
      rst = 1'b1;
      model_clear();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_hold_data_o", data_o, 32'h0);
         check("rst_hold_verify", verify, 32'h0);
         @(posedge clk);
      end
      #1 rst = 1'b0;
      step("post_rst", 1'b1, 1'b0, 32'h8, 32'h0);

      // Write then read back word 2; verify still shows the old value before the edge.
      ce = 1'b1; we = 1'b1; addr = 32'h8; data_i = 32'h12345678;
      @(negedge clk);
      check("wr_pre_verify", verify, 32'h0);
      check("wr_data_o_zero", data_o, 32'h0);
      @(posedge clk);
      model[2] = 32'h12345678;
      #1;
      ce = 1'b1; we = 1'b0; addr = 32'h8;
      #1;
      check("rd_data_o", data_o, 32'h12345678);
      check("rd_verify", verify, 32'h12345678);

      // Misaligned write aligns down.
      step("mis_wr", 1'b1, 1'b1, 32'h0D, 32'hA5A5A5A5);
      step("mis_rd", 1'b1, 1'b0, 32'h0C, 32'h0);
      ce = 1'b1; we = 1'b0; addr = 32'h0C; #1;
      check("mis_rd_const", data_o, 32'hA5A5A5A5);
`ifdef DMEM_ERR_EN
      check("mis_err_const", {31'h0, err_o}, 32'h1);
`endif

      // Out-of-range write is dropped.
      step("oor_wr", 1'b1, 1'b1, 32'h1000, 32'hFFFFFFFF);
      step("oor_rd0", 1'b1, 1'b0, 32'h0, 32'h0);
      step("oor_rd1000", 1'b1, 1'b0, 32'h1000, 32'h0);
      ce = 1'b1; we = 1'b0; addr = 32'h0; #1;
      check("oor_word0_const", data_o, 32'h0);

      // we without ce is ignored.
      step("nce_wr", 1'b0, 1'b1, 32'h8, 32'h55);
      ce = 1'b1; we = 1'b0; addr = 32'h8; #1;
      check("nce_word2_const", data_o, 32'h12345678);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] a;
         int sel;
         sel = $urandom_range(0, 9);
         if (sel < 4)       a = {$urandom_range(0, 15), 2'b00};
         else if (sel < 6)  a = {$urandom_range(0, DEPTH - 1), 2'b00};
         else if (sel < 8)  a = {$urandom_range(0, 15), 2'b00} | 32'($urandom_range(1, 3));
         else if (sel == 8) a = 32'h1000 + ($urandom & 32'h0FFF_FFFF);
         else               a = 32'h8;
         step("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, $urandom);
      end

      // Reset raised mid-cycle during a valid write: reset wins.
      ce = 1'b1; we = 1'b1; addr = 32'h4; data_i = 32'h77;
      @(negedge clk);
      rst = 1'b1;
      model_clear();
      #1;
      check("race_rst_verify", verify, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      step("race_rd", 1'b1, 1'b0, 32'h4, 32'h0);
      ce = 1'b1; we = 1'b0; addr = 32'h4; #1;
      check("race_word1_const", data_o, 32'h0);
`ifdef DMEM_ERR_EN
      check("race_err_cleared", {31'h0, err_o}, 32'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
